// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: execute-stage request port plus request/grant/response data-bus signals.
interface mem_ctrl_if;
  logic        req_sel_i;
  logic        req_wen_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [1:0]  req_size_i;
  logic        ack_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic        busy_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_i;
  modport slave (
    input  req_sel_i, req_wen_i, req_addr_i, req_wdata_i, req_size_i,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
    output ack_o, err_o, rdata_o, busy_o,
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o
  );
  modport master (
    output req_sel_i, req_wen_i, req_addr_i, req_wdata_i, req_size_i,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
    input  ack_o, err_o, rdata_o, busy_o,
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: runs one load/store per execute-stage request on the data bus, with alignment and timeout errors.
module mem_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input logic       clk,
  input logic       rst_n,
  mem_ctrl_if.slave m
);
  typedef enum logic [2:0] {IDLE, REQ, RESP, DONE, REL} state_t;
  state_t     state;
  logic [7:0] cnt;
  logic       legal;
  logic [3:0] be;
  logic       timeout;
  assign legal = (m.req_size_i == 2'b00) ||
                 (m.req_size_i == 2'b01 && !m.req_addr_i[0]) ||
                 (m.req_size_i == 2'b10 && m.req_addr_i[1:0] == 2'b00);
  assign be = m.req_size_i == 2'b00 ? 4'b0001 << m.req_addr_i[1:0] :
              m.req_size_i == 2'b01 ? (m.req_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign timeout = cnt == 8'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      m.ack_o       <= 1'b0;
      m.err_o       <= 1'b0;
      m.rdata_o     <= '0;
      m.busy_o      <= 1'b0;
      m.bus_req_o   <= 1'b0;
      m.bus_we_o    <= 1'b0;
      m.bus_addr_o  <= '0;
      m.bus_wdata_o <= '0;
      m.bus_be_o    <= '0;
    end else begin
      m.ack_o <= 1'b0;
      m.err_o <= 1'b0;
      case (state)
        IDLE: if (m.req_sel_i) begin
          cnt      <= '0;
          m.busy_o <= 1'b1;
          if (legal) begin
            m.bus_req_o   <= 1'b1;
            m.bus_we_o    <= m.req_wen_i;
            m.bus_addr_o  <= {m.req_addr_i[31:2], 2'b00};
            m.bus_wdata_o <= m.req_wdata_i;
            m.bus_be_o    <= be;
            state         <= REQ;
          end else begin
            m.ack_o <= 1'b1;
            m.err_o <= 1'b1;
            state   <= DONE;
          end
        end
        // timeout wins over a grant arriving in the same cycle
        REQ: if (timeout) begin
          m.bus_req_o <= 1'b0;
          m.ack_o     <= 1'b1;
          m.err_o     <= 1'b1;
          state       <= DONE;
        end else begin
          cnt <= cnt + 8'd1;
          if (m.bus_gnt_i) begin
            m.bus_req_o <= 1'b0;
            state       <= RESP;
          end
        end
        RESP: if (m.bus_rvalid_i) begin
          if (!m.bus_we_o) m.rdata_o <= m.bus_rdata_i;
          m.ack_o <= 1'b1;
          m.err_o <= m.bus_err_i;
          state   <= DONE;
        end else if (timeout) begin
          m.ack_o <= 1'b1;
          m.err_o <= 1'b1;
          state   <= DONE;
        end else begin
          cnt <= cnt + 8'd1;
        end
        DONE: state <= REL;
        REL: if (!m.req_sel_i) begin
          m.busy_o <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
